// File: rtl/uRISC_pkg.sv
// Shared uRISC opcode map, immediate classes and the opcode-to-control lookup.
// Pure definitions; no state, no latency, no flow control.
// Backpressure: n/a.
package uRISC_pkg;

    localparam int DW_DEFAULT   = 16;
    localparam int NREG_DEFAULT = 8;

    typedef enum logic [4:0] {
        OP_ADD  = 5'd0,
        OP_SUB  = 5'd1,
        OP_AND  = 5'd2,
        OP_OR   = 5'd3,
        OP_ADDI = 5'd4,
        OP_LD   = 5'd5,
        OP_ST   = 5'd6,
        OP_LI   = 5'd7,
        OP_J    = 5'd8,
        OP_JAL  = 5'd9
    } opcode_e;

    typedef enum logic [1:0] {
        IC_R,
        IC_I1,
        IC_I2,
        IC_J
    } imm_class_e;

    typedef struct packed {
        logic       legal;
        imm_class_e cls;
        logic       regwrite;
        logic       memrd;
        logic       memwr;
        logic       uses_rs;
        logic       uses_rt;
    } ctrl_t;

    // Anything not listed decodes as illegal with every control bit low.
    function automatic ctrl_t lookup_ctrl(input logic [4:0] op);
        ctrl_t c;
        c = '0;
        c.cls = IC_R;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                c.legal = 1'b1; c.regwrite = 1'b1; c.uses_rs = 1'b1; c.uses_rt = 1'b1;
            end
            OP_ADDI: begin
                c.legal = 1'b1; c.cls = IC_I1; c.regwrite = 1'b1; c.uses_rs = 1'b1;
            end
            OP_LD: begin
                c.legal = 1'b1; c.cls = IC_I1; c.regwrite = 1'b1; c.memrd = 1'b1; c.uses_rs = 1'b1;
            end
            OP_ST: begin
                c.legal = 1'b1; c.cls = IC_I1; c.memwr = 1'b1; c.uses_rs = 1'b1; c.uses_rt = 1'b1;
            end
            OP_LI: begin
                c.legal = 1'b1; c.cls = IC_I2; c.regwrite = 1'b1;
            end
            OP_J: begin
                c.legal = 1'b1; c.cls = IC_J;
            end
            OP_JAL: begin
                c.legal = 1'b1; c.cls = IC_J; c.regwrite = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/regfile.sv
// Register file: two async read ports, one write port; REGFILE_BYPASS_EN makes reads write-through.
// Reads are combinational, writes land on the clock edge.
// Backpressure: none, the write port is always accepted.
module regfile
    import uRISC_pkg::*;
#(
    parameter int  DW   = DW_DEFAULT,
    parameter int  NREG = NREG_DEFAULT,
    localparam int AW   = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wen_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_a_i,
    input  logic [AW-1:0] raddr_b_i,
    output logic [DW-1:0] rdata_a_o,
    output logic [DW-1:0] rdata_b_o
);

    logic [DW-1:0] regs_q [NREG];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wen_i) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

`ifdef REGFILE_BYPASS_EN
    assign rdata_a_o = (wen_i && (waddr_i == raddr_a_i)) ? wdata_i : regs_q[raddr_a_i];
    assign rdata_b_o = (wen_i && (waddr_i == raddr_b_i)) ? wdata_i : regs_q[raddr_b_i];
`else
    assign rdata_a_o = regs_q[raddr_a_i];
    assign rdata_b_o = regs_q[raddr_b_i];
`endif

endmodule

// File: rtl/decode_unit.sv
// uRISC decode stage feeding the ID/EX register; REGFILE_BYPASS_EN selects write-through reads.
// Latency: 1 cycle from an accepted instruction to valid_idex.
// Backpressure: stall_ifid holds fetch one cycle on a load-use hazard; flush overrides it.
module decode_unit
    import uRISC_pkg::*;
#(
    parameter int  DW   = DW_DEFAULT,
    parameter int  NREG = NREG_DEFAULT,
    localparam int AW   = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] inst_ifid,
    input  logic          valid_ifid,
    output logic          stall_ifid,
    input  logic          flush,
    input  logic          wb_en,
    input  logic [AW-1:0] wb_reg,
    input  logic [DW-1:0] wb_data,
    output logic          valid_idex,
    output logic [4:0]    opcode_idex,
    output logic [DW-1:0] rs_data_idex,
    output logic [DW-1:0] rt_data_idex,
    output logic [DW-1:0] imm_idex,
    output logic [AW-1:0] rd_idex,
    output logic          regwrite_idex,
    output logic          memrd_idex,
    output logic          memwr_idex,
    output logic          err
);

    ctrl_t         ctrl;
    logic [4:0]    op;
    logic [AW-1:0] rs_idx, rt_idx, rd_sel;
    logic [DW-1:0] imm_sel, rs_rdata, rt_rdata;
    logic          hazard, accept;

    logic          valid_q, valid_d;
    logic [4:0]    opcode_q, opcode_d;
    logic [DW-1:0] rs_q, rs_d, rt_q, rt_d, imm_q, imm_d;
    logic [AW-1:0] rd_q, rd_d;
    logic          regwrite_q, regwrite_d, memrd_q, memrd_d, memwr_q, memwr_d;
    logic          err_q, err_d;

    assign op     = inst_ifid[15:11];
    assign rs_idx = inst_ifid[10:8];
    assign rt_idx = inst_ifid[7:5];
    assign ctrl   = lookup_ctrl(op);

    regfile #(.DW(DW), .NREG(NREG)) u_regfile (
        .clk       (clk),
        .rst       (rst),
        .wen_i     (wb_en),
        .waddr_i   (wb_reg),
        .wdata_i   (wb_data),
        .raddr_a_i (rs_idx),
        .raddr_b_i (rt_idx),
        .rdata_a_o (rs_rdata),
        .rdata_b_o (rt_rdata)
    );

    always_comb begin
        imm_sel = '0;
        rd_sel  = '0;
        case (ctrl.cls)
            IC_R:  rd_sel = inst_ifid[4:2];
            IC_I1: begin
                imm_sel = {{(DW-5){inst_ifid[4]}}, inst_ifid[4:0]};
                rd_sel  = inst_ifid[7:5];
            end
            IC_I2: begin
                imm_sel = {{(DW-8){inst_ifid[7]}}, inst_ifid[7:0]};
                rd_sel  = inst_ifid[10:8];
            end
            IC_J: begin
                imm_sel = {{(DW-11){inst_ifid[10]}}, inst_ifid[10:0]};
                rd_sel  = '1;
            end
            default: ;
        endcase
    end

    // Only a load still sitting in ID/EX can produce a value too late to forward.
    assign hazard = valid_ifid && valid_q && memrd_q &&
                    ((ctrl.uses_rs && (rd_q == rs_idx)) || (ctrl.uses_rt && (rd_q == rt_idx)));
    assign stall_ifid = hazard && !flush;
    assign accept     = valid_ifid && ctrl.legal && !hazard && !flush;

    always_comb begin
        valid_d    = 1'b0;
        opcode_d   = '0;
        rs_d       = '0;
        rt_d       = '0;
        imm_d      = '0;
        rd_d       = '0;
        regwrite_d = 1'b0;
        memrd_d    = 1'b0;
        memwr_d    = 1'b0;
        err_d      = err_q || (valid_ifid && !ctrl.legal && !flush);
        if (accept) begin
            valid_d    = 1'b1;
            opcode_d   = op;
            rs_d       = rs_rdata;
            rt_d       = rt_rdata;
            imm_d      = imm_sel;
            rd_d       = rd_sel;
            regwrite_d = ctrl.regwrite;
            memrd_d    = ctrl.memrd;
            memwr_d    = ctrl.memwr;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q    <= 1'b0;
            opcode_q   <= '0;
            rs_q       <= '0;
            rt_q       <= '0;
            imm_q      <= '0;
            rd_q       <= '0;
            regwrite_q <= 1'b0;
            memrd_q    <= 1'b0;
            memwr_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            opcode_q   <= opcode_d;
            rs_q       <= rs_d;
            rt_q       <= rt_d;
            imm_q      <= imm_d;
            rd_q       <= rd_d;
            regwrite_q <= regwrite_d;
            memrd_q    <= memrd_d;
            memwr_q    <= memwr_d;
            err_q      <= err_d;
        end
    end

    assign valid_idex    = valid_q;
    assign opcode_idex   = opcode_q;
    assign rs_data_idex  = rs_q;
    assign rt_data_idex  = rt_q;
    assign imm_idex      = imm_q;
    assign rd_idex       = rd_q;
    assign regwrite_idex = regwrite_q;
    assign memrd_idex    = memrd_q;
    assign memwr_idex    = memwr_q;
    assign err           = err_q;

endmodule

// File: tb/tb_decode_unit.sv
// Randomized bench for decode_unit against a behavioural pipeline model, plus directed scenarios.
module tb_decode_unit;

    localparam logic [4:0] ADD = 5'd0, ADDI = 5'd4, LD = 5'd5, LI = 5'd7, J = 5'd8, JAL = 5'd9;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] inst_ifid;
    logic        valid_ifid, stall_ifid, flush, wb_en;
    logic [2:0]  wb_reg;
    logic [15:0] wb_data;
    logic        valid_idex, regwrite_idex, memrd_idex, memwr_idex, err;
    logic [4:0]  opcode_idex;
    logic [15:0] rs_data_idex, rt_data_idex, imm_idex;
    logic [2:0]  rd_idex;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    decode_unit #(.DW(16), .NREG(8)) dut (
        .clk(clk), .rst(rst), .inst_ifid(inst_ifid), .valid_ifid(valid_ifid),
        .stall_ifid(stall_ifid), .flush(flush), .wb_en(wb_en), .wb_reg(wb_reg),
        .wb_data(wb_data), .valid_idex(valid_idex), .opcode_idex(opcode_idex),
        .rs_data_idex(rs_data_idex), .rt_data_idex(rt_data_idex), .imm_idex(imm_idex),
        .rd_idex(rd_idex), .regwrite_idex(regwrite_idex), .memrd_idex(memrd_idex),
        .memwr_idex(memwr_idex), .err(err)
    );

    // Behavioural model state: architectural registers and the expected ID/EX contents.
    logic [15:0] mreg [8];
    logic        m_valid, m_rw, m_mr, m_mw, m_err;
    logic [4:0]  m_op;
    logic [15:0] m_rs, m_rt, m_imm;
    logic [2:0]  m_rd;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] enc_r(input logic [4:0] op, input logic [2:0] rs, rt, rd);
        return {op, rs, rt, rd, 2'b00};
    endfunction
    function automatic logic [15:0] enc_i1(input logic [4:0] op, input logic [2:0] rs, rd, input logic [4:0] imm);
        return {op, rs, rd, imm};
    endfunction
    function automatic logic [15:0] enc_i2(input logic [4:0] op, input logic [2:0] rd, input logic [7:0] imm);
        return {op, rd, imm};
    endfunction
    function automatic logic [15:0] enc_j(input logic [4:0] op, input logic [10:0] imm);
        return {op, imm};
    endfunction

    function automatic int sext(input int v, input int bits);
        return (v >= (1 << (bits - 1))) ? v - (1 << bits) : v;
    endfunction

    function automatic bit reads_reg(input logic [15:0] ins, input logic [2:0] r);
        int op = int'(ins[15:11]);
        if (op <= 3 || op == 6) return (r == ins[10:8]) || (r == ins[7:5]);
        if (op == 4 || op == 5) return r == ins[10:8];
        return 1'b0;
    endfunction

    function automatic bit model_stall();
        return valid_ifid && !flush && m_valid && m_mr && reads_reg(inst_ifid, m_rd);
    endfunction

    function automatic logic [15:0] rdval(input logic [2:0] idx);
`ifdef REGFILE_BYPASS_EN
        if (wb_en && wb_reg == idx) return wb_data;
`endif
        return mreg[idx];
    endfunction

    task automatic model_zero();
        m_valid = 0; m_rw = 0; m_mr = 0; m_mw = 0; m_err = 0;
        m_op = '0; m_rs = '0; m_rt = '0; m_imm = '0; m_rd = '0;
        for (int i = 0; i < 8; i++) mreg[i] = '0;
    endtask

    task automatic model_edge();
        int op, v;
        bit legal, take;
        logic [15:0] ra, rb;
        op    = int'(inst_ifid[15:11]);
        legal = op <= 9;
        ra    = rdval(inst_ifid[10:8]);
        rb    = rdval(inst_ifid[7:5]);
        take  = valid_ifid && legal && !flush && !model_stall();
        if (valid_ifid && !legal && !flush) m_err = 1;
        m_valid = 0; m_rw = 0; m_mr = 0; m_mw = 0;
        m_op = '0; m_rs = '0; m_rt = '0; m_imm = '0; m_rd = '0;
        if (take) begin
            m_valid = 1;
            m_op = 5'(op);
            m_rs = ra;
            m_rt = rb;
            m_rw = (op != 6) && (op != 8);
            m_mr = (op == 5);
            m_mw = (op == 6);
            if (op <= 3)      v = 0;
            else if (op <= 6) v = sext(int'(inst_ifid & 16'h001F), 5);
            else if (op == 7) v = sext(int'(inst_ifid & 16'h00FF), 8);
            else              v = sext(int'(inst_ifid & 16'h07FF), 11);
            m_imm = 16'(v);
            if (op <= 3)      m_rd = inst_ifid[4:2];
            else if (op <= 6) m_rd = inst_ifid[7:5];
            else if (op == 7) m_rd = inst_ifid[10:8];
            else              m_rd = 3'd7;
        end
        if (wb_en) mreg[wb_reg] = wb_data;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("stall_ifid",    stall_ifid,    model_stall());
            check("valid_idex",    valid_idex,    m_valid);
            check("opcode_idex",   opcode_idex,   m_op);
            check("rs_data_idex",  rs_data_idex,  m_rs);
            check("rt_data_idex",  rt_data_idex,  m_rt);
            check("imm_idex",      imm_idex,      m_imm);
            check("rd_idex",       rd_idex,       m_rd);
            check("regwrite_idex", regwrite_idex, m_rw);
            check("memrd_idex",    memrd_idex,    m_mr);
            check("memwr_idex",    memwr_idex,    m_mw);
            check("err",           err,           m_err);
        end
    end

    task automatic drive(input logic [15:0] ins, input bit v, input bit fl,
                         input bit we, input logic [2:0] wr, input logic [15:0] wd);
        inst_ifid = ins; valid_ifid = v; flush = fl; wb_en = we; wb_reg = wr; wb_data = wd;
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_edge();
        #1;
    endtask

    task automatic cycle(input logic [15:0] ins, input bit v, input bit fl,
                         input bit we, input logic [2:0] wr, input logic [15:0] wd);
        drive(ins, v, fl, we, wr, wd);
        tick();
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        model_zero();
        #1;
        check("rst_async_valid", valid_idex, 0);
        check("rst_async_err",   err,        0);
        check("rst_async_stall", stall_ifid, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        bit held;
        rst = 1'b0;
        drive('0, 0, 0, 0, '0, '0);
        model_zero();
        chk_en = 1'b1;
        #3;
        check("reset_valid", valid_idex, 0);
        check("reset_imm",   imm_idex,   0);
        check("reset_err",   err,        0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // R3 <- 0x1234 then ADD R1,R3,R2
        cycle('0, 0, 0, 1, 3'd3, 16'h1234);
        cycle(enc_r(ADD, 3'd3, 3'd2, 3'd1), 1, 0, 0, '0, '0);
        check("add_valid", valid_idex, 1);
        check("add_rs",    rs_data_idex, 16'h1234);
        check("add_rd",    rd_idex, 3'd1);

        cycle(enc_i1(ADDI, 3'd0, 3'd1, 5'b10000), 1, 0, 0, '0, '0);
        check("addi_imm", imm_idex, 16'hFFF0);
        check("addi_rd",  rd_idex, 3'd1);
        cycle(enc_i2(LI, 3'd6, 8'h80), 1, 0, 0, '0, '0);
        check("li_imm", imm_idex, 16'hFF80);
        check("li_rd",  rd_idex, 3'd6);
        cycle(enc_j(J, 11'h400), 1, 0, 0, '0, '0);
        check("j_imm", imm_idex, 16'hFC00);
        check("j_rw",  regwrite_idex, 0);
        cycle(enc_j(JAL, 11'h3FF), 1, 0, 0, '0, '0);
        check("jal_imm", imm_idex, 16'h03FF);
        check("jal_rd",  rd_idex, 3'd7);

        // Load-use: LD R2 then ADD R4,R2,R1
        cycle(enc_i1(LD, 3'd0, 3'd2, 5'd0), 1, 0, 0, '0, '0);
        check("ld_memrd", memrd_idex, 1);
        drive(enc_r(ADD, 3'd2, 3'd1, 3'd4), 1, 0, 0, '0, '0);
        #1;
        check("lu_stall", stall_ifid, 1);
        tick();
        check("lu_bubble", valid_idex, 0);
        check("lu_stall_drop", stall_ifid, 0);
        tick();
        check("lu_issue", valid_idex, 1);
        check("lu_issue_rd", rd_idex, 3'd4);
        cycle('0, 0, 0, 0, '0, '0);
        check("lu_once", valid_idex, 0);

        // Same-cycle write and read of R5
        cycle('0, 0, 0, 1, 3'd5, 16'h1111);
        cycle(enc_r(ADD, 3'd5, 3'd0, 3'd1), 1, 0, 1, 3'd5, 16'hBEEF);
`ifdef REGFILE_BYPASS_EN
        check("wb_same_cycle", rs_data_idex, 16'hBEEF);
`else
        check("wb_same_cycle", rs_data_idex, 16'h1111);
`endif
        cycle(enc_r(ADD, 3'd5, 3'd0, 3'd1), 1, 0, 0, '0, '0);
        check("wb_after", rs_data_idex, 16'hBEEF);

        // Illegal opcode
        cycle(enc_j(5'b11111, 11'h0), 1, 0, 0, '0, '0);
        check("ill_err",    err, 1);
        check("ill_bubble", valid_idex, 0);
        cycle('0, 0, 0, 0, '0, '0);
        check("ill_err_held", err, 1);
        apply_reset();
        check("ill_err_clr", err, 0);

        // Flush during a load-use stall
        cycle(enc_i1(LD, 3'd0, 3'd3, 5'd1), 1, 0, 0, '0, '0);
        drive(enc_r(ADD, 3'd3, 3'd0, 3'd2), 1, 1, 0, '0, '0);
        #1;
        check("flush_stall", stall_ifid, 0);
        tick();
        check("flush_bubble", valid_idex, 0);

        // Reset in the middle of a stall
        cycle(enc_i1(LD, 3'd0, 3'd2, 5'd0), 1, 0, 0, '0, '0);
        drive(enc_r(ADD, 3'd2, 3'd2, 3'd6), 1, 0, 0, '0, '0);
        #1;
        check("mid_stall", stall_ifid, 1);
        apply_reset();
        tick();
        check("post_rst_accept", valid_idex, 1);
        check("post_rst_rd", rd_idex, 3'd6);

        held = 1'b0;
        for (int i = 0; i < 400; i++) begin
            logic [4:0]  op;
            logic [15:0] ins;
            bit          v;
            if (i == 200) apply_reset();
            if (held) begin
                ins = inst_ifid;
                v   = valid_ifid;
            end else begin
                op  = ($urandom_range(0, 39) == 0) ? 5'd31 : 5'($urandom_range(0, 9));
                ins = {op, 11'($urandom)};
                v   = $urandom_range(0, 4) != 0;
            end
            drive(ins, v, $urandom_range(0, 9) == 0, 1'($urandom_range(0, 1)),
                  3'($urandom), 16'($urandom));
            #1;
            held = model_stall();
            tick();
        end

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
